// File: rtl/edge_img_streamer.sv
// edge_img_streamer: raster-order readout of the edge image memory
// onto a valid/ready stream through a 2-entry FIFO.
module edge_img_streamer #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 16,
  parameter int IMAGE_COLUMN_SIZE = 256,
  parameter int IMAGE_ROW_SIZE    = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_col_o,
  output logic                  m_last_frame_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                  start_q;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic                  done_q, done_d;

  logic                  pend_q;
  logic                  pend_lc_q;
  logic                  pend_lf_q;

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [1:0]            lc_q;
  logic [1:0]            lf_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic                  start_edge;
  logic                  valid;
  logic                  pop;
  logic                  push;
  logic [2:0]            occ;
  logic                  rd_en;
  logic                  is_last_col;
  logic                  is_last_frame;

  assign start_edge    = start_i & ~start_q;
  assign valid         = (count_q != 2'd0);
  assign pop           = valid & m_ready_i;
  assign push          = pend_q;
  assign occ           = {1'b0, count_q} + {2'b00, pend_q};
  assign rd_en         = (state_q == S_READ) &&
                         (occ < (pop ? 3'd3 : 3'd2));
  assign is_last_col   = (col_q == ADDR_WIDTH'(IMAGE_COLUMN_SIZE - 1));
  assign is_last_frame = is_last_col &&
                         (row_q == ADDR_WIDTH'(IMAGE_ROW_SIZE - 1));

  assign rd_en_o        = rd_en;
  assign rd_addr_o      = cnt_q;
  assign m_valid_o      = valid;
  assign m_data_o       = valid ? mem_q[rd_ptr_q] : '0;
  assign m_last_col_o   = valid & lc_q[rd_ptr_q];
  assign m_last_frame_o = valid & lf_q[rd_ptr_q];
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;

  // Next-state logic for the frame FSM and the raster counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_READ;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_READ: begin
        if (rd_en) begin
          if (is_last_frame) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (is_last_col) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (pop && m_last_frame_o) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counters, start sampler and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // In-flight read tracking and FIFO occupancy/pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= 1'b0;
      pend_lc_q <= 1'b0;
      pend_lf_q <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      pend_q    <= rd_en;
      pend_lc_q <= is_last_col;
      pend_lf_q <= is_last_frame;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO payload storage; outputs are gated by valid so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rd_data_i;
      lc_q[wr_ptr_q]  <= pend_lc_q;
      lf_q[wr_ptr_q]  <= pend_lf_q;
    end
  end

endmodule

// File: tb/tb_edge_img_streamer.sv
// tb_edge_img_streamer: directed frames with random back-pressure,
// checked against a frame-level reference model.
module tb_edge_img_streamer;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_col_o;
  logic          m_last_frame_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  edge_img_streamer #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW),
    .IMAGE_COLUMN_SIZE(COLS),
    .IMAGE_ROW_SIZE   (ROWS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .rd_en_o       (rd_en_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_last_col_o  (m_last_col_o),
    .m_last_frame_o(m_last_frame_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int t_start   = 0;
  int rd_idx    = 0;
  int xi        = 0;
  int issued    = 0;
  int xfers     = 0;
  int done_cnt  = 0;
  bit first_seen = 0;
  bit start_prev = 0;
  bit hold_prev  = 0;
  bit done_prev  = 0;
  bit in_frame   = 0;
  bit full_speed = 0;
  bit chain      = 0;

  logic [DW-1:0] hold_data;
  logic          hold_lc;
  logic          hold_lf;
  logic          mem_en = 1'b0;
  logic [AW-1:0] mem_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en_o), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_o), 0);
    chk({tag, "_valid"}, 32'(m_valid_o), 0);
    chk({tag, "_data"}, 32'(m_data_o), 0);
    chk({tag, "_lc"}, 32'(m_last_col_o), 0);
    chk({tag, "_lf"}, 32'(m_last_frame_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
  endtask

  // One clock cycle: observe at negedge, advance past posedge,
  // then present memory read data for the previous cycle's read.
  task automatic step();
    int pop;
    @(negedge clk);
    if (rst_i) begin
      rd_idx = 0; xi = 0; issued = 0; xfers = 0;
      first_seen = 0; start_prev = 0; hold_prev = 0;
      done_prev = 0; in_frame = 0;
    end else begin
      pop = (m_valid_o && m_ready_i) ? 1 : 0;
      if (rd_en_o) begin
        chk("rd_addr", 32'(rd_addr_o), 32'(rd_idx));
        chk("issue_rule", 32'((issued - xfers - pop) < 2), 1);
        rd_idx++;
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(m_valid_o), 1);
        chk("hold_data", 32'(m_data_o), 32'(hold_data));
        chk("hold_lc", 32'(m_last_col_o), 32'(hold_lc));
        chk("hold_lf", 32'(m_last_frame_o), 32'(hold_lf));
      end
      if (m_valid_o && in_frame && !first_seen) begin
        first_seen = 1;
        chk("first_valid_lat", 32'(cyc - t_start), 3);
      end
      if (pop != 0) begin
        chk("data", 32'(m_data_o), 32'((xi + 10) % 256));
        chk("last_col", 32'(m_last_col_o), 32'((xi % COLS) == COLS - 1));
        chk("last_frame", 32'(m_last_frame_o), 32'(xi == N - 1));
        xi++;
      end
      if (done_prev) chk("done_width", 32'(done_o), 0);
      if (done_o) begin
        done_cnt++;
        chk("done_busy", 32'(busy_o), 0);
        chk("done_xfers", 32'(xi), N);
        chk("done_reads", 32'(rd_idx), N);
        if (full_speed) chk("frame_time", 32'(cyc - t_start), N + 3);
        in_frame = 0;
        if (chain) begin
          start_i = 1'b1;
          chain   = 0;
        end
      end
      if (start_i && !start_prev && !busy_o) begin
        t_start = cyc; rd_idx = 0; xi = 0;
        first_seen = 0; in_frame = 1;
      end
      start_prev = start_i;
      done_prev  = done_o;
      hold_prev  = m_valid_o && !m_ready_i;
      hold_data  = m_data_o;
      hold_lc    = m_last_col_o;
      hold_lf    = m_last_frame_o;
      if (rd_en_o) issued++;
      xfers += pop;
    end
    mem_en   = rd_en_o;
    mem_addr = rd_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    rd_data_i = mem_en ? DW'(mem_addr + AW'(10)) : DW'($urandom);
  endtask

  task automatic run_frame(input int mode, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      m_ready_i = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      step();
    end
    if (done_cnt == d0) chk("timeout", 0, 1);
  endtask

  initial begin
    int d0;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    m_ready_i = 1'b0;
    rd_data_i = '0;
    #1;
    step();
    step();
    rst_i = 1'b0;
    chk_zero("reset");

    // Full-speed frame, chained into a back-to-back frame.
    full_speed = 1;
    m_ready_i  = 1'b1;
    start_i    = 1'b1;
    step();
    start_i = 1'b0;
    chain   = 1;
    run_frame(0, 60);
    step();
    start_i = 1'b0;
    run_frame(0, 60);
    chk("b2b_frames", 32'(done_cnt), 2);

    // Random back-pressure.
    full_speed = 0;
    repeat (3) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_frame(1, 300);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_frame(1, 300);

    // Consumer stalled for 10 cycles after start.
    m_ready_i = 1'b0;
    start_i   = 1'b1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    chk("stall_reads", 32'(rd_idx), 2);
    chk("stall_valid", 32'(m_valid_o), 1);
    chk("stall_data", 32'(m_data_o), 10);
    chk("stall_rd_en", 32'(rd_en_o), 0);
    run_frame(0, 60);

    // Start held high with a mid-frame re-pulse: one frame only.
    full_speed = 1;
    d0 = done_cnt;
    start_i = 1'b1;
    step();
    repeat (5) step();
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    run_frame(0, 60);
    repeat (5) begin
      step();
      chk("held_start_idle", 32'(busy_o), 0);
    end
    chk("held_start_frames", 32'(done_cnt - d0), 1);
    start_i = 1'b0;
    step();

    // Reset mid-frame with a read in flight.
    d0 = done_cnt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 20 && xi < 5; i++) step();
    chk("pre_reset_xfers", 32'(xi), 5);
    chk("pre_reset_inflight", 32'(rd_en_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_zero("midreset");
    repeat (3) begin
      step();
      chk("post_reset_valid", 32'(m_valid_o), 0);
      chk("post_reset_busy", 32'(busy_o), 0);
    end
    chk("post_reset_no_done", 32'(done_cnt - d0), 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_frame(0, 60);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
